// File: rtl/aca_ii_vl_if.sv
// aca_ii_vl operand/result handshake bundle.
// master drives operands and out_ready; slave is the adder.
interface aca_ii_vl_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         CIN;
  logic         exact_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] SUM;
  logic         COUT;
  logic         ERR;
  logic         CORRECTED;

  modport master (
    output in_valid, A, B, CIN, exact_mode, out_ready,
    input  in_ready, out_valid, SUM, COUT, ERR, CORRECTED
  );

  modport slave (
    input  in_valid, A, B, CIN, exact_mode, out_ready,
    output in_ready, out_valid, SUM, COUT, ERR, CORRECTED
  );
endinterface

// File: rtl/aca_ii_vl.sv
// Variable-latency error-correcting ACA-II adder.
// Optional ERR result counter: define ACA_ERR_CNT_EN.
module aca_ii_vl #(
  parameter int N = 16,
  parameter int R = 4,
  parameter int P = 4
) (
  input  logic        clk,
  input  logic        rst,
  aca_ii_vl_if.slave  bus
`ifdef ACA_ERR_CNT_EN
  ,
  output logic [15:0] err_count,
  output logic [0:0]  err_count_sat
`endif
);

  typedef enum logic {RUN, CORR} state_t;

  state_t       st, st_n;
  logic [N-1:0] sa, se, sq;
  logic         ca, ce, cq;
  logic         err;
  logic [R+P-1:0] lo_s;
  logic         lo_c;
  logic [R:0]   hi;
  logic [N-1:0] a_q, b_q;
  logic         c_q;
  logic         in_rdy, ld, cap;
  logic [N-1:0] sum_n, sum_q;
  logic         cout_n, err_n, corr_n;
  logic         cout_q, err_q, corr_q, ov_q;

  // Approximate sum: exact low window, then speculative chunks
  always_comb begin
    {lo_c, lo_s} = {1'b0, bus.A[R+P-1:0]}
                 + {1'b0, bus.B[R+P-1:0]}
                 + (R+P+1)'(bus.CIN);
    sa = '0;
    sa[R+P-1:0] = lo_s;
    ca = lo_c;
    hi = '0;
    for (int c = (R+P)/R; c < N/R; c++) begin
      hi = (R+1)'(({1'b0, bus.A[c*R-P +: R+P]}
                 + {1'b0, bus.B[c*R-P +: R+P]}) >> P);
      sa[c*R +: R] = hi[R-1:0];
      ca = hi[R];
    end
  end

  assign {ce, se} = {1'b0, bus.A} + {1'b0, bus.B}
                  + (N+1)'(bus.CIN);
  assign {cq, sq} = {1'b0, a_q} + {1'b0, b_q}
                  + (N+1)'(c_q);
  assign err = {ca, sa} != {ce, se};

  // Next state, handshake and output-register load select
  always_comb begin
    st_n   = st;
    in_rdy = 1'b0;
    ld     = 1'b0;
    cap    = 1'b0;
    sum_n  = sa;
    cout_n = ca;
    err_n  = err;
    corr_n = 1'b0;
    unique case (st)
      RUN: begin
        in_rdy = !ov_q || bus.out_ready;
        if (bus.in_valid && in_rdy) begin
          if (bus.exact_mode && err) begin
            cap  = 1'b1;
            st_n = CORR;
          end else begin
            ld = 1'b1;
          end
        end
      end
      CORR: begin
        if (!ov_q || bus.out_ready) begin
          ld     = 1'b1;
          sum_n  = sq;
          cout_n = cq;
          err_n  = 1'b1;
          corr_n = 1'b1;
          st_n   = RUN;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= RUN;
    else     st <= st_n;
  end

  // Operand capture for the correction cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
    end else if (cap) begin
      a_q <= bus.A;
      b_q <= bus.B;
      c_q <= bus.CIN;
    end
  end

  // Output register: load when empty or draining, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
      corr_q <= 1'b0;
    end else if (ld) begin
      ov_q   <= 1'b1;
      sum_q  <= sum_n;
      cout_q <= cout_n;
      err_q  <= err_n;
      corr_q <= corr_n;
    end else if (bus.out_ready) begin
      ov_q   <= 1'b0;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ov_q;
  assign bus.SUM       = sum_q;
  assign bus.COUT      = cout_q;
  assign bus.ERR       = err_q;
  assign bus.CORRECTED = corr_q;

`ifdef ACA_ERR_CNT_EN
  logic [15:0] cnt_q;

  // Saturating count of delivered ERR results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (ov_q && bus.out_ready && err_q
             && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign err_count     = cnt_q;
  assign err_count_sat = 1'(cnt_q == 16'hFFFF);
`endif

endmodule

// File: tb/tb_aca_ii_vl.sv
// Testbench for aca_ii_vl (N=16, R=4, P=4).
// Scoreboard model plus directed latency/handshake checks.
module tb_aca_ii_vl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  aca_ii_vl_if #(.N(16)) bus ();

`ifdef ACA_ERR_CNT_EN
  logic [15:0] err_count;
  logic [0:0]  err_count_sat;
  int          ecnt = 0;
`endif

  aca_ii_vl #(.N(16), .R(4), .P(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ACA_ERR_CNT_EN
    ,
    .err_count     (err_count),
    .err_count_sat (err_count_sat)
`endif
  );

  always #5 clk = ~clk;

  // Result model: {CORRECTED, ERR, COUT, SUM}
  function automatic logic [18:0] model(
    input logic [15:0] a, input logic [15:0] b,
    input logic cin, input logic em);
    int unsigned ex, apx, t;
    logic err;
    ex  = int'(a) + int'(b) + int'(cin);
    apx = (int'(a & 16'hFF) + int'(b & 16'hFF) + int'(cin)) & 32'hFF;
    t   = 0;
    for (int c = 2; c < 4; c++) begin
      t = ((int'(a) >> (4*c-4)) & 32'hFF)
        + ((int'(b) >> (4*c-4)) & 32'hFF);
      apx = apx | (((t >> 4) & 32'hF) << (4*c));
    end
    apx = apx | (((t >> 8) & 32'h1) << 16);
    err = (apx != ex);
    if (em && err) model = {2'b11, ex[16:0]};
    else           model = {1'b0, err, apx[16:0]};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [18:0] q[$];
  logic        hold = 1'b0;
  logic [18:0] held;
  logic [18:0] e;

  // Scoreboard: check every delivered result and every held cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
`ifdef ACA_ERR_CNT_EN
      ecnt = 0;
`endif
    end else begin
      if (hold)
        chk("stable", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}),
            32'(held));
`ifdef ACA_ERR_CNT_EN
      chk("err_count", 32'(err_count), 32'(ecnt));
      chk("err_sat", 32'(err_count_sat), 32'(ecnt == 65535));
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %h expected none", bus.SUM);
        end else begin
          e = q.pop_front();
          chk("result", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}),
              32'(e));
`ifdef ACA_ERR_CNT_EN
          if (e[17] && ecnt < 65535) ecnt++;
`endif
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      held = {bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM};
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.A, bus.B, bus.CIN, bus.exact_mode));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic em);
    bus.in_valid   = 1'b1;
    bus.A          = a;
    bus.B          = b;
    bus.CIN        = cin;
    bus.exact_mode = em;
  endtask

  // Present one operand set and return just after it is accepted
  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic em);
    int n;
    set_op(a, b, cin, em);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      cyc();
      n++;
    end
    if (n == 20) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    cyc();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.CIN        = 1'b0;
    bus.exact_mode = 1'b0;
    bus.out_ready  = 1'b1;
    cyc();
    cyc();
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_out", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}), 0);
    rst = 1'b0;
    chk("rst_ir", 32'(bus.in_ready), 1);

    chk("m_free", 32'(model(16'h1234, 16'h4321, 0, 1)), 32'h05555);
    chk("m_apx", 32'(model(16'h00FF, 16'h0001, 0, 0)), 32'h20000);
    chk("m_cor", 32'(model(16'h00FF, 16'h0001, 0, 1)), 32'h60100);
    chk("m_co_apx", 32'(model(16'hFFFF, 16'h0001, 0, 0)), 32'h2FF00);
    chk("m_co_cor", 32'(model(16'hFFFF, 16'h0001, 0, 1)), 32'h70000);
    chk("m_cin", 32'(model(16'h0FFF, 16'h0000, 1, 0)), 32'h20F00);

    set_op(16'h1234, 16'h4321, 1'b0, 1'b1);
    cyc();
    chk("t1_ov", 32'(bus.out_valid), 1);
    chk("t1_sum", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}),
        32'h05555);
    for (int i = 0; i < 4; i++) begin
      set_op(16'(i * 16'h0111), 16'h0101, 1'b0, 1'b1);
      chk("b2b_ir", 32'(bus.in_ready), 1);
      cyc();
      chk("b2b_ov", 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    cyc();

    set_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    cyc();
    chk("t2_ov", 32'(bus.out_valid), 1);
    chk("t2_out", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}),
        32'h20000);

    set_op(16'h00FF, 16'h0001, 1'b0, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    chk("t3_ir", 32'(bus.in_ready), 0);
    chk("t3_ov", 32'(bus.out_valid), 0);
    cyc();
    chk("t3_ov2", 32'(bus.out_valid), 1);
    chk("t3_out", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}),
        32'h60100);
    chk("t3_ir2", 32'(bus.in_ready), 1);

    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("t4_apx", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}),
        32'h2FF00);
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    cyc();
    chk("t4_cor", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}),
        32'h70000);
    drive(16'h0FFF, 16'h0000, 1'b1, 1'b1);
    drive(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    drive(16'h7FF0, 16'h0010, 1'b0, 1'b1);
    cyc();
    cyc();

    bus.out_ready = 1'b0;
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
    set_op(16'h1111, 16'h2222, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ir", 32'(bus.in_ready), 0);
      cyc();
    end
    chk("bp_out", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}),
        32'h20000);
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("bp_ov", 32'(bus.out_valid), 1);
    chk("bp_new", 32'(bus.SUM), 32'h3333);
    cyc();

    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    cyc();
    chk("hold_cor", 32'(bus.CORRECTED), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_ov", 32'(bus.out_valid), 0);
    chk("arst_out", 32'({bus.CORRECTED, bus.ERR, bus.COUT, bus.SUM}), 0);
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;

    drive(16'h00FF, 16'h0001, 1'b0, 1'b1);
    chk("mc_ir", 32'(bus.in_ready), 0);
    #1 rst = 1'b1;
    #1;
    chk("mc_ov", 32'(bus.out_valid), 0);
    cyc();
    rst = 1'b0;
    chk("mc_ir2", 32'(bus.in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mc_nostale", 32'(bus.out_valid), 0);
    end

    drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1);
    drive(16'h0001, 16'h0001, 1'b0, 1'b1);
    repeat (4) cyc();
    chk("sb_empty", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
